tri_frame_feeder: RTL and testbench

- Upstream stage of the triangle-check core. Accepts packed 3-side words over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each word into the core's 3-cycle IN_VALID/INPUT frame, then waits for the core's OUT_VALID/OUT result, with a timeout.
- Re-publishes each result with pass/frame counters for the system/host side.

---
 rtl/tri_frame_feeder.sv | 117 +++++++++++
 tb/tb_tri_frame_feeder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tri_frame_feeder.sv
// tri_frame_feeder: FIFO-buffered serializer of packed 3-side words into the triangle core's 3-cycle frame, with result/timeout reporting
// Ports: CLK, RST_N (async active-low); S_VALID/S_READY/S_DATA upstream word handshake; IN_VALID/INPUT frame elements to core;
//        OUT_VALID/OUT core result; R_VALID pulse with R_DATA/R_TIMEOUT; FRAME_CNT/PASS_CNT wrapping 8-bit counters.
module tri_frame_feeder #(
  parameter int DEPTH = 4,
  parameter int GAP = 1,
  parameter int TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       S_VALID,
  output logic       S_READY,
  input  logic [8:0] S_DATA,
  output logic       IN_VALID,
  output logic [2:0] INPUT,
  input  logic       OUT_VALID,
  input  logic       OUT,
  output logic       R_VALID,
  output logic       R_DATA,
  output logic       R_TIMEOUT,
  output logic [7:0] FRAME_CNT,
  output logic [7:0] PASS_CNT
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, SEND0, SEND1, SEND2, WAIT, GAPW} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [8:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] count_q, count_d;
  logic s_ready_q, s_ready_d, in_valid_q, in_valid_d;
  logic r_valid_q, r_valid_d, r_data_q, r_data_d, r_timeout_q, r_timeout_d;
  logic [2:0] input_q, input_d;
  logic [7:0] frame_cnt_q, frame_cnt_d, pass_cnt_q, pass_cnt_d;
  logic push, pop, nonempty, res, tmo;
  logic [8:0] head;
  assign push = S_VALID && s_ready_q;
  assign pop = state_q == SEND2;
  assign nonempty = count_q != '0;
  assign head = mem_q[rd_q];
  // a result seen on the timeout cycle wins over the timeout
  assign res = state_q == WAIT && OUT_VALID;
  assign tmo = state_q == WAIT && !OUT_VALID && cnt_q == 8'(TIMEOUT);
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      s_ready_q <= 1'b0;
      in_valid_q <= 1'b0;
      input_q <= '0;
      r_valid_q <= 1'b0;
      r_data_q <= 1'b0;
      r_timeout_q <= 1'b0;
      frame_cnt_q <= '0;
      pass_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      s_ready_q <= s_ready_d;
      in_valid_q <= in_valid_d;
      input_q <= input_d;
      r_valid_q <= r_valid_d;
      r_data_q <= r_data_d;
      r_timeout_q <= r_timeout_d;
      frame_cnt_q <= frame_cnt_d;
      pass_cnt_q <= pass_cnt_d;
    end
  always_ff @(posedge CLK)
    if (push) mem_q[wr_q] <= S_DATA;
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    case (state_q)
      IDLE:  state_d = nonempty ? SEND0 : IDLE;
      SEND0: state_d = SEND1;
      SEND1: state_d = SEND2;
      SEND2: state_d = WAIT;
      WAIT: begin
        state_d = (res || tmo) ? GAPW : WAIT;
        cnt_d = (res || tmo) ? '0 : cnt_q + 8'd1;
      end
      GAPW: begin
        state_d = cnt_q == 8'(GAP - 1) ? (nonempty ? SEND0 : IDLE) : GAPW;
        cnt_d = cnt_q == 8'(GAP - 1) ? '0 : cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs are registered, so they are decoded from the state being entered
  always_comb begin
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    s_ready_d = count_d != (AW+1)'(DEPTH);
    in_valid_d = state_d inside {SEND0, SEND1, SEND2};
    input_d = state_d == SEND0 ? head[8:6] : state_d == SEND1 ? head[5:3] : state_d == SEND2 ? head[2:0] : 3'd0;
    r_valid_d = res || tmo;
    r_data_d = res ? OUT : tmo ? 1'b0 : r_data_q;
    r_timeout_d = tmo ? 1'b1 : res ? 1'b0 : r_timeout_q;
    frame_cnt_d = frame_cnt_q + 8'(r_valid_d);
    pass_cnt_d = pass_cnt_q + 8'(res && OUT);
  end
  assign S_READY = s_ready_q;
  assign IN_VALID = in_valid_q;
  assign INPUT = input_q;
  assign R_VALID = r_valid_q;
  assign R_DATA = r_data_q;
  assign R_TIMEOUT = r_timeout_q;
  assign FRAME_CNT = frame_cnt_q;
  assign PASS_CNT = pass_cnt_q;
endmodule

// File: tb/tb_tri_frame_feeder.sv
// tb_tri_frame_feeder: directed plus randomized self-checking bench for tri_frame_feeder
module tb_tri_frame_feeder;
  localparam int DEPTH = 4, GAP = 1, TIMEOUT = 15;
  logic CLK = 0, RST_N = 0, S_VALID = 0, OUT_VALID = 0, OUT = 0;
  logic [8:0] S_DATA = '0;
  logic S_READY, IN_VALID, R_VALID, R_DATA, R_TIMEOUT;
  logic [2:0] INPUT;
  logic [7:0] FRAME_CNT, PASS_CNT;
  int n_chk = 0, n_fail = 0, cyc = 0, prev_rv = -1000, exp_frame = 0, exp_pass = 0;
  logic last_rd = 0, last_to = 0;
  logic [8:0] q[$];
  int qa[$];
  tri_frame_feeder #(.DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N), .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
    .IN_VALID(IN_VALID), .INPUT(INPUT), .OUT_VALID(OUT_VALID), .OUT(OUT),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_TIMEOUT(R_TIMEOUT),
    .FRAME_CNT(FRAME_CNT), .PASS_CNT(PASS_CNT)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t expected below 1000000", $time);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
  // word is accepted on the edge after a negedge that sees S_READY high
  task automatic push(input logic [8:0] w);
    int n;
    n = 0;
    S_VALID = 1;
    S_DATA = w;
    while (!S_READY && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (!S_READY) chk("push_accept", S_READY, 1);
    else begin
      q.push_back(w);
      qa.push_back(cyc + 1);
    end
    @(negedge CLK);
  endtask
  task automatic frame(input int d, input bit resp, input logic ob, input bit spur);
    logic [8:0] w;
    int a, n, kend;
    bit stray, early;
    n = 0;
    stray = 0;
    early = 0;
    do begin
      @(negedge CLK);
      n++;
      stray |= R_VALID;
    end while (!IN_VALID && n < 500);
    chk("frame_start", IN_VALID, 1);
    chk("single_pulse", stray, 0);
    if (!IN_VALID) return;
    chk("frame_queued", q.size() != 0, 1);
    if (q.size() == 0) return;
    w = q.pop_front();
    a = qa.pop_front();
    chk("start_cycle", cyc, max2(prev_rv + GAP, a + 1));
    chk("hold_r_data", R_DATA, last_rd);
    chk("hold_r_timeout", R_TIMEOUT, last_to);
    chk("in_a", INPUT, w[8:6]);
    @(negedge CLK);
    if (spur) begin
      OUT_VALID = 1;
      OUT = 1;
    end
    chk("iv_b", IN_VALID, 1);
    chk("in_b", INPUT, w[5:3]);
    @(negedge CLK);
    OUT_VALID = 0;
    chk("iv_c", IN_VALID, 1);
    chk("in_c", INPUT, w[2:0]);
    @(negedge CLK);
    chk("iv_off", IN_VALID, 0);
    chk("in_off", INPUT, 0);
    kend = resp ? d : TIMEOUT;
    for (int k = 0; k <= kend; k++) begin
      if (k > 0) @(negedge CLK);
      early |= R_VALID;
      OUT_VALID = resp && k == d;
      OUT = OUT_VALID ? ob : 1'($urandom);
    end
    @(negedge CLK);
    OUT_VALID = 0;
    OUT = 0;
    chk("no_early_rvalid", early, 0);
    chk("r_valid", R_VALID, 1);
    exp_frame++;
    if (resp && ob) exp_pass++;
    last_rd = resp ? ob : 1'b0;
    last_to = !resp;
    chk("r_data", R_DATA, last_rd);
    chk("r_timeout", R_TIMEOUT, last_to);
    chk("frame_cnt", FRAME_CNT, exp_frame % 256);
    chk("pass_cnt", PASS_CNT, exp_pass % 256);
    prev_rv = cyc;
  endtask
  initial begin
    int bad;
    repeat (2) @(negedge CLK);
    chk("rst_s_ready", S_READY, 0);
    chk("rst_in_valid", IN_VALID, 0);
    chk("rst_input", INPUT, 0);
    chk("rst_r_valid", R_VALID, 0);
    chk("rst_r_data", R_DATA, 0);
    chk("rst_r_timeout", R_TIMEOUT, 0);
    chk("rst_frame_cnt", FRAME_CNT, 0);
    chk("rst_pass_cnt", PASS_CNT, 0);
    RST_N = 1;
    @(negedge CLK);
    chk("s_ready_after_rst", S_READY, 1);
    fork
      begin push(9'h1FF); S_VALID = 0; end
      frame(2, 1, 1, 0);
    join
    fork
      begin push(9'h051); push(9'h0C9); push(9'h0E6); S_VALID = 0; end
      begin frame(1, 1, 0, 0); frame(1, 1, 0, 0); frame(1, 1, 1, 0); end
    join
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          push(9'($urandom));
          if (i == 3) chk("full_after_4", S_READY, 0);
        end
        S_VALID = 0;
      end
      begin
        frame(0, 0, 0, 0);
        frame(0, 0, 0, 0);
        frame(TIMEOUT, 1, 1, 0);
        for (int i = 0; i < 3; i++) frame($urandom_range(0, TIMEOUT), 1, 1'($urandom), 0);
      end
    join
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (R_VALID) bad++;
      OUT_VALID = 1;
      OUT = 1;
    end
    @(negedge CLK);
    OUT_VALID = 0;
    if (R_VALID) bad++;
    chk("spur_idle_rvalid", bad, 0);
    chk("spur_idle_frames", FRAME_CNT, exp_frame % 256);
    chk("spur_idle_pass", PASS_CNT, exp_pass % 256);
    fork
      begin push(9'($urandom)); S_VALID = 0; end
      frame(3, 1, 0, 1);
    join
    fork
      begin
        for (int i = 0; i < 250; i++) begin
          repeat ($urandom_range(0, 3)) begin
            S_VALID = 0;
            S_DATA = 9'($urandom);
            @(negedge CLK);
          end
          push(9'($urandom));
        end
        S_VALID = 0;
      end
      for (int i = 0; i < 250; i++)
        frame($urandom_range(0, TIMEOUT), $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0);
    join
    fork
      begin push(9'($urandom)); S_VALID = 0; end
      frame(0, 1, 1, 0);
    join
    fork
      begin push(9'h0E6); push(9'h1FF); push(9'h051); S_VALID = 0; end
      begin
        bad = 0;
        do begin
          @(negedge CLK);
          bad++;
        end while (!IN_VALID && bad < 100);
        chk("rst_frame_start", IN_VALID, 1);
        repeat (6) @(negedge CLK);
        #2 RST_N = 0;
        #1;
        chk("mid_rst_s_ready", S_READY, 0);
        chk("mid_rst_in_valid", IN_VALID, 0);
        chk("mid_rst_input", INPUT, 0);
        chk("mid_rst_r_valid", R_VALID, 0);
        chk("mid_rst_r_data", R_DATA, 0);
        chk("mid_rst_r_timeout", R_TIMEOUT, 0);
        chk("mid_rst_frame_cnt", FRAME_CNT, 0);
        chk("mid_rst_pass_cnt", PASS_CNT, 0);
      end
    join
    repeat (2) @(negedge CLK);
    chk("held_rst_s_ready", S_READY, 0);
    RST_N = 1;
    q.delete();
    qa.delete();
    exp_frame = 0;
    exp_pass = 0;
    last_rd = 0;
    last_to = 0;
    prev_rv = -1000;
    @(negedge CLK);
    chk("s_ready_after_mid_rst", S_READY, 1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (IN_VALID || R_VALID) bad++;
    end
    chk("no_activity_after_rst", bad, 0);
    chk("frame_cnt_after_rst", FRAME_CNT, 0);
    fork
      begin push(9'h0C9); S_VALID = 0; end
      frame(4, 1, 0, 0);
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
